clk_div_delay_tap_ctrl: RTL and testbench

- Sequencer for the delay line inside the clock-divider/delay primitive on the RX IOD clock path.
- Accepts LOAD, INC and DEC commands from the bit-align training logic.
- Converts each command into correctly spaced DELAY_LINE_LOAD/DIR/MOVE pulses, tracks the absolute tap position and reports range errors.
- Sits between the training FSM and the clock-divider instance. It owns the delay-line control pins.

---
 rtl/clk_div_delay_tap_ctrl.sv | 152 +++++++++++++++
 tb/tb_clk_div_delay_tap_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_delay_tap_ctrl.sv
// Delay-line tap sequencer for the RX IOD clock-divider primitive: turns LOAD/INC/DEC
// commands into spaced LOAD/DIR/MOVE pulses. Optional ABORT input: CLK_DIV_DELAY_TAP_CTRL_ABORT_EN.
module clk_div_delay_tap_ctrl #(
   parameter int TAP_WIDTH   = 8,
   parameter int MAX_TAP     = 127,
   parameter int INIT_TAP    = 1,
   parameter int LOAD_CYCLES = 2,
   parameter int MOVE_GAP    = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CMD_VALID,
   output logic                 CMD_READY,
   input  logic [1:0]           CMD_OP,
   input  logic [TAP_WIDTH-1:0] CMD_COUNT,
   output logic                 DONE,
   output logic                 ERR,
   output logic                 BUSY,
   output logic [TAP_WIDTH-1:0] TAP_POS,
   output logic                 DELAY_LINE_LOAD,
   output logic                 DELAY_LINE_DIR,
   output logic                 DELAY_LINE_MOVE,
   input  logic                 DELAY_LINE_OUT_OF_RANGE
`ifdef CLK_DIV_DELAY_TAP_CTRL_ABORT_EN
   , input logic                ABORT
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETDIR, S_MOVE, S_GAP, S_FIN} state_t;

   localparam logic [1:0]           OP_LOAD = 2'b00;
   localparam logic [1:0]           OP_INC  = 2'b01;
   localparam logic [1:0]           OP_DEC  = 2'b10;
   localparam logic [1:0]           OP_RSVD = 2'b11;
   localparam logic [TAP_WIDTH-1:0] MAX_T   = TAP_WIDTH'(MAX_TAP);
   localparam logic [TAP_WIDTH-1:0] INIT_T  = TAP_WIDTH'(INIT_TAP);
   localparam logic [3:0]           LOAD_T  = 4'(LOAD_CYCLES - 1);
   localparam logic [3:0]           GAP_T   = 4'(MOVE_GAP - 1);

   state_t               state;
   state_t               state_nxt;
   logic [1:0]           op_q;
   logic [TAP_WIDTH-1:0] rem;
   logic [TAP_WIDTH-1:0] tap_pos;
   logic [3:0]           timer;
   logic                 dir_q;
   logic                 err_q;
   logic                 oor_s1;
   logic                 oor_s2;
   logic                 accept;
   logic                 range_err;
   logic                 move_pulse;
   logic                 abort_req;

`ifdef CLK_DIV_DELAY_TAP_CTRL_ABORT_EN
   assign abort_req = ABORT;
`else
   assign abort_req = 1'b0;
`endif

   // Handshake: a command transfers on the CLK edge where CMD_VALID && CMD_READY;
   // CMD_READY is high only in IDLE and op/count are captured on that edge only.
   assign accept     = CMD_VALID && CMD_READY;
   assign range_err  = ((op_q == OP_INC) && (tap_pos == MAX_T)) ||
                       ((op_q == OP_DEC) && (tap_pos == '0)) || oor_s2;
   assign move_pulse = (state == S_MOVE) && !range_err;

   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (CMD_OP)
                  OP_LOAD:        state_nxt = S_LOAD;
                  OP_INC, OP_DEC: state_nxt = (CMD_COUNT == '0) ? S_FIN : S_SETDIR;
                  default:        state_nxt = S_FIN;
               endcase
            end
         end
         S_LOAD:   if (timer == '0) state_nxt = S_FIN;
         S_SETDIR: state_nxt = abort_req ? S_FIN : S_MOVE;
         S_MOVE:   state_nxt = (range_err || abort_req) ? S_FIN : S_GAP;
         S_GAP: begin
            if (abort_req)          state_nxt = S_FIN;
            else if (timer == '0)   state_nxt = (rem != '0) ? S_MOVE : S_FIN;
         end
         S_FIN:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      CMD_READY       = (state == S_IDLE);
      BUSY            = (state != S_IDLE);
      DONE            = (state == S_FIN);
      DELAY_LINE_LOAD = (state == S_LOAD);
      DELAY_LINE_MOVE = move_pulse;
      DELAY_LINE_DIR  = dir_q;
      ERR             = err_q;
      TAP_POS         = tap_pos;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         op_q    <= OP_LOAD;
         rem     <= '0;
         tap_pos <= INIT_T;
         timer   <= '0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
         oor_s1  <= 1'b0;
         oor_s2  <= 1'b0;
      end else begin
         oor_s1 <= DELAY_LINE_OUT_OF_RANGE;
         oor_s2 <= oor_s1;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q  <= CMD_OP;
                  rem   <= CMD_COUNT;
                  timer <= LOAD_T;
                  err_q <= (CMD_OP == OP_RSVD);
                  // DIR is set a cycle ahead of the first MOVE and otherwise left alone
                  if (((CMD_OP == OP_INC) || (CMD_OP == OP_DEC)) && (CMD_COUNT != '0))
                     dir_q <= (CMD_OP == OP_INC);
               end
            end
            S_LOAD: begin
               if (timer != '0) timer   <= timer - 4'd1;
               else             tap_pos <= INIT_T;
            end
            S_MOVE: begin
               if (range_err) begin
                  err_q <= 1'b1;
               end else begin
                  tap_pos <= dir_q ? tap_pos + TAP_WIDTH'(1) : tap_pos - TAP_WIDTH'(1);
                  rem     <= rem - TAP_WIDTH'(1);
                  timer   <= GAP_T;
               end
            end
            S_GAP: if (timer != '0) timer <= timer - 4'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_div_delay_tap_ctrl.sv
// Directed bench for clk_div_delay_tap_ctrl: one task per scenario with hand-computed
// expectations (MOVE_GAP=4, LOAD_CYCLES=2, MAX_TAP=127, INIT_TAP=1).
module tb_clk_div_delay_tap_ctrl;

   logic       CLK;
   logic       RST;
   logic       CMD_VALID;
   logic       CMD_READY;
   logic [1:0] CMD_OP;
   logic [7:0] CMD_COUNT;
   logic       DONE;
   logic       ERR;
   logic       BUSY;
   logic [7:0] TAP_POS;
   logic       DELAY_LINE_LOAD;
   logic       DELAY_LINE_DIR;
   logic       DELAY_LINE_MOVE;
   logic       DELAY_LINE_OUT_OF_RANGE;
`ifdef CLK_DIV_DELAY_TAP_CTRL_ABORT_EN
   logic       ABORT;
`endif

   int   checks;
   int   failures;
   int   mv_cnt, ld_cnt, done_at, first_mv, oor_after, abort_at;
   logic done_err, gap_bad, overlap, dir_pre;

   clk_div_delay_tap_ctrl dut (
      .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_OP(CMD_OP), .CMD_COUNT(CMD_COUNT), .DONE(DONE), .ERR(ERR), .BUSY(BUSY),
      .TAP_POS(TAP_POS), .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_DIR(DELAY_LINE_DIR),
      .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE)
`ifdef CLK_DIV_DELAY_TAP_CTRL_ABORT_EN
      , .ABORT(ABORT)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Issues one command and observes cycles 1..budget after the accept edge until DONE.
   task automatic run_cmd(input logic [1:0] op, input logic [7:0] cnt, input int budget);
      int   prev_mv;
      logic prev_dir;
      mv_cnt = 0; ld_cnt = 0; done_at = -1; done_err = 1'b0; gap_bad = 1'b0;
      overlap = 1'b0; first_mv = -1; dir_pre = 1'b0; prev_mv = -1; prev_dir = DELAY_LINE_DIR;
      CMD_OP = op; CMD_COUNT = cnt; CMD_VALID = 1'b1;
      step();
      CMD_VALID = 1'b0; CMD_OP = ~op; CMD_COUNT = ~cnt;
      for (int k = 1; k <= budget; k++) begin
`ifdef CLK_DIV_DELAY_TAP_CTRL_ABORT_EN
         ABORT = (k == abort_at);
`endif
         if (DELAY_LINE_MOVE && DELAY_LINE_LOAD) overlap = 1'b1;
         if (DELAY_LINE_MOVE) begin
            if (prev_mv >= 0 && (k - prev_mv) != 5) gap_bad = 1'b1;
            if (first_mv < 0) begin first_mv = k; dir_pre = prev_dir; end
            prev_mv = k;
            mv_cnt++;
            if (oor_after != 0 && mv_cnt == oor_after) DELAY_LINE_OUT_OF_RANGE = 1'b1;
         end
         if (DELAY_LINE_LOAD) ld_cnt++;
         if (DONE) begin done_at = k; done_err = ERR; break; end
         prev_dir = DELAY_LINE_DIR;
         step();
      end
`ifdef CLK_DIV_DELAY_TAP_CTRL_ABORT_EN
      ABORT = 1'b0;
`endif
   endtask

   task automatic test_reset();
      RST = 1'b1;
      step(); step();
      checks++; if (CMD_READY !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", CMD_READY); end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
      checks++; if (DONE !== 1'b0 || ERR !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%b%b exp=00", DONE, ERR); end
      checks++; if (TAP_POS !== 8'd1) begin failures++; $display("FAIL reset_tap got=%0d exp=1", TAP_POS); end
      checks++; if ({DELAY_LINE_LOAD, DELAY_LINE_DIR, DELAY_LINE_MOVE} !== 3'b000) begin
         failures++; $display("FAIL reset_pins got=%b exp=000", {DELAY_LINE_LOAD, DELAY_LINE_DIR, DELAY_LINE_MOVE}); end
      RST = 1'b0;
      step();
   endtask

   task automatic test_load(input logic [7:0] exp_before);
      checks++; if (TAP_POS !== exp_before) begin failures++; $display("FAIL load_pre_tap got=%0d exp=%0d", TAP_POS, exp_before); end
      run_cmd(2'b00, 8'd9, 20);
      checks++; if (ld_cnt !== 2) begin failures++; $display("FAIL load_pulse_len got=%0d exp=2", ld_cnt); end
      checks++; if (done_at !== 3) begin failures++; $display("FAIL load_done_cycle got=%0d exp=3", done_at); end
      checks++; if (mv_cnt !== 0) begin failures++; $display("FAIL load_moves got=%0d exp=0", mv_cnt); end
      checks++; if (TAP_POS !== 8'd1) begin failures++; $display("FAIL load_tap got=%0d exp=1", TAP_POS); end
      checks++; if (done_err !== 1'b0) begin failures++; $display("FAIL load_err got=%b exp=0", done_err); end
      step();
      checks++; if (DONE !== 1'b0 || CMD_READY !== 1'b1) begin failures++; $display("FAIL load_after got=%b%b exp=01", DONE, CMD_READY); end
   endtask

   task automatic test_inc();
      run_cmd(2'b01, 8'd3, 40);
      checks++; if (mv_cnt !== 3) begin failures++; $display("FAIL inc_moves got=%0d exp=3", mv_cnt); end
      checks++; if (first_mv !== 2) begin failures++; $display("FAIL inc_first_move got=%0d exp=2", first_mv); end
      checks++; if (dir_pre !== 1'b1) begin failures++; $display("FAIL inc_dir_setup got=%b exp=1", dir_pre); end
      checks++; if (gap_bad !== 1'b0) begin failures++; $display("FAIL inc_spacing got=%b exp=0", gap_bad); end
      checks++; if (done_at !== 17) begin failures++; $display("FAIL inc_done_cycle got=%0d exp=17", done_at); end
      checks++; if (TAP_POS !== 8'd4) begin failures++; $display("FAIL inc_tap got=%0d exp=4", TAP_POS); end
      checks++; if (done_err !== 1'b0 || overlap !== 1'b0) begin failures++; $display("FAIL inc_err_overlap got=%b%b exp=00", done_err, overlap); end
      step();
      checks++; if (DELAY_LINE_DIR !== 1'b1) begin failures++; $display("FAIL inc_dir_hold got=%b exp=1", DELAY_LINE_DIR); end
   endtask

   task automatic test_dec_underflow();
      run_cmd(2'b10, 8'd2, 40);
      checks++; if (TAP_POS !== 8'd2 || done_at !== 12) begin failures++; $display("FAIL dec2 got=%0d/%0d exp=2/12", TAP_POS, done_at); end
      checks++; if (dir_pre !== 1'b0) begin failures++; $display("FAIL dec_dir_setup got=%b exp=0", dir_pre); end
      step();
      run_cmd(2'b10, 8'd5, 60);
      checks++; if (mv_cnt !== 2) begin failures++; $display("FAIL dec_under_moves got=%0d exp=2", mv_cnt); end
      checks++; if (TAP_POS !== 8'd0) begin failures++; $display("FAIL dec_under_tap got=%0d exp=0", TAP_POS); end
      checks++; if (done_at !== 13 || done_err !== 1'b1) begin failures++; $display("FAIL dec_under_done got=%0d/%b exp=13/1", done_at, done_err); end
      step();
      checks++; if (ERR !== 1'b1 || CMD_READY !== 1'b1) begin failures++; $display("FAIL err_hold got=%b%b exp=11", ERR, CMD_READY); end
   endtask

   task automatic test_inc_overflow();
      run_cmd(2'b01, 8'd125, 700);
      checks++; if (TAP_POS !== 8'd125 || done_err !== 1'b0) begin failures++; $display("FAIL inc125 got=%0d/%b exp=125/0", TAP_POS, done_err); end
      step();
      run_cmd(2'b01, 8'd5, 60);
      checks++; if (mv_cnt !== 2) begin failures++; $display("FAIL over_moves got=%0d exp=2", mv_cnt); end
      checks++; if (TAP_POS !== 8'd127) begin failures++; $display("FAIL over_tap got=%0d exp=127", TAP_POS); end
      checks++; if (done_at !== 13 || done_err !== 1'b1) begin failures++; $display("FAIL over_done got=%0d/%b exp=13/1", done_at, done_err); end
      step();
   endtask

   task automatic test_out_of_range();
      logic mv_ok;
      oor_after = 2;
      run_cmd(2'b01, 8'd10, 80);
      oor_after = 0;
      DELAY_LINE_OUT_OF_RANGE = 1'b0;
      mv_ok = (mv_cnt >= 2) && (mv_cnt <= 3);
      checks++; if (mv_ok !== 1'b1) begin failures++; $display("FAIL oor_moves got=%0d exp=2..3", mv_cnt); end
      checks++; if (done_err !== 1'b1 || done_at < 0) begin failures++; $display("FAIL oor_done got=%0d/%b exp=done/1", done_at, done_err); end
      checks++; if (TAP_POS !== 8'(1 + mv_cnt)) begin failures++; $display("FAIL oor_tap got=%0d exp=%0d", TAP_POS, 1 + mv_cnt); end
      step(); step(); step();
   endtask

   task automatic test_back_to_back();
      int k1, mv1, k2, mv2;
      k1 = -1; mv1 = 0; k2 = -1; mv2 = 0;
      CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_COUNT = 8'd1;
      step();
      CMD_COUNT = 8'd3;
      for (int k = 1; k <= 40; k++) begin
         if (DELAY_LINE_MOVE) mv1++;
         if (DONE) begin k1 = k; break; end
         step();
      end
      checks++; if (k1 !== 7 || mv1 !== 1) begin failures++; $display("FAIL held_first got=%0d/%0d exp=7/1", k1, mv1); end
      checks++; if (CMD_READY !== 1'b0) begin failures++; $display("FAIL held_ready_fin got=%b exp=0", CMD_READY); end
      step();
      checks++; if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL held_idle got=%b%b exp=10", CMD_READY, BUSY); end
      step();
      CMD_VALID = 1'b0;
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL held_second_accept got=%b exp=1", BUSY); end
      for (int k = 1; k <= 40; k++) begin
         if (DELAY_LINE_MOVE) mv2++;
         if (DONE) begin k2 = k; break; end
         step();
      end
      checks++; if (k2 !== 17 || mv2 !== 3) begin failures++; $display("FAIL held_second got=%0d/%0d exp=17/3", k2, mv2); end
      checks++; if (TAP_POS !== 8'd5) begin failures++; $display("FAIL held_tap got=%0d exp=5", TAP_POS); end
      step();
   endtask

   task automatic test_reset_mid();
      int bad;
      bad = 0;
      CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_COUNT = 8'd8;
      step();
      CMD_VALID = 1'b0;
      step();
      checks++; if (DELAY_LINE_MOVE !== 1'b1) begin failures++; $display("FAIL mid_first_move got=%b exp=1", DELAY_LINE_MOVE); end
      step(); step();
      RST = 1'b1;
      step();
      checks++; if (DELAY_LINE_MOVE !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
         failures++; $display("FAIL mid_reset_outputs got=%b%b%b exp=000", DELAY_LINE_MOVE, BUSY, DONE); end
      checks++; if (TAP_POS !== 8'd1) begin failures++; $display("FAIL mid_reset_tap got=%0d exp=1", TAP_POS); end
      RST = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (DELAY_LINE_MOVE || DONE || BUSY) bad++;
         step();
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL mid_reset_quiet got=%0d exp=0", bad); end
   endtask

   task automatic test_zero_and_reserved();
      run_cmd(2'b01, 8'd0, 10);
      checks++; if (done_at !== 1 || mv_cnt !== 0) begin failures++; $display("FAIL zero_count got=%0d/%0d exp=1/0", done_at, mv_cnt); end
      checks++; if (done_err !== 1'b0 || TAP_POS !== 8'd1) begin failures++; $display("FAIL zero_err_tap got=%b/%0d exp=0/1", done_err, TAP_POS); end
      step();
      run_cmd(2'b11, 8'd5, 10);
      checks++; if (done_at !== 1 || done_err !== 1'b1) begin failures++; $display("FAIL rsvd_done got=%0d/%b exp=1/1", done_at, done_err); end
      checks++; if (mv_cnt !== 0 || ld_cnt !== 0) begin failures++; $display("FAIL rsvd_pulses got=%0d/%0d exp=0/0", mv_cnt, ld_cnt); end
      step();
      checks++; if (ERR !== 1'b1) begin failures++; $display("FAIL rsvd_err_hold got=%b exp=1", ERR); end
   endtask

`ifdef CLK_DIV_DELAY_TAP_CTRL_ABORT_EN
   task automatic test_abort();
      abort_at = 4;
      run_cmd(2'b01, 8'd6, 60);
      abort_at = -1;
      checks++; if (done_at !== 5 || done_err !== 1'b0) begin failures++; $display("FAIL abort_done got=%0d/%b exp=5/0", done_at, done_err); end
      checks++; if (mv_cnt !== 1 || TAP_POS !== 8'd2) begin failures++; $display("FAIL abort_moves got=%0d/%0d exp=1/2", mv_cnt, TAP_POS); end
      step();
   endtask
`endif

   initial begin
      checks = 0; failures = 0; oor_after = 0; abort_at = -1;
      RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_COUNT = 8'd0;
      DELAY_LINE_OUT_OF_RANGE = 1'b0;
`ifdef CLK_DIV_DELAY_TAP_CTRL_ABORT_EN
      ABORT = 1'b0;
`endif
      test_reset();
      test_load(8'd1);
      test_inc();
      test_dec_underflow();
      test_inc_overflow();
      test_load(8'd127);
      test_out_of_range();
      test_load(8'd3);
      test_back_to_back();
      test_reset_mid();
      test_zero_and_reserved();
`ifdef CLK_DIV_DELAY_TAP_CTRL_ABORT_EN
      test_abort();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
